// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with a 2-entry skid buffer, flush, MemToReg select,
// forwarding qualifiers and a retired-instruction counter.
module mem_wb_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [1:0]            WB_i,
  input  logic [DATA_W-1:0]     ReadData_i,
  input  logic [DATA_W-1:0]     ALUResult_i,
  input  logic [REG_ADDR_W-1:0] RegDst_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  RegWrite_o,
  output logic [REG_ADDR_W-1:0] RegDst_o,
  output logic [DATA_W-1:0]     WriteData_o,
  output logic                  fwd_valid_o,
  output logic [CNT_W-1:0]      retired_o
);

  typedef struct packed {
    logic [1:0]            wb;   // [0]=MemToReg, [1]=RegWrite
    logic [DATA_W-1:0]     rd;
    logic [DATA_W-1:0]     alu;
    logic [REG_ADDR_W-1:0] dst;
  } entry_t;

  entry_t            m_q, s_q, in_e;
  logic              m_vld, s_vld;
  logic [CNT_W-1:0]  cnt;
  logic              accept, handoff;

  assign in_e    = '{wb: WB_i, rd: ReadData_i, alu: ALUResult_i, dst: RegDst_i};
  assign ready_o = !s_vld;
  assign accept  = valid_i & ready_o;
  assign handoff = m_vld & ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_q   <= '0;
      s_q   <= '0;
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      cnt   <= '0;
    end else if (flush_i) begin
      // Flush drops both entries and any coinciding input; no retire credit.
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else begin
      if (handoff) cnt <= cnt + 1'b1;
      if (s_vld) begin
        if (handoff) begin
          m_q   <= s_q;
          s_vld <= 1'b0;
        end
      end else if (m_vld) begin
        if (accept && handoff) begin
          m_q <= in_e;
        end else if (handoff) begin
          m_vld <= 1'b0;
        end else if (accept) begin
          s_q   <= in_e;
          s_vld <= 1'b1;
        end
      end else if (accept) begin
        m_q   <= in_e;
        m_vld <= 1'b1;
      end
    end
  end

  assign valid_o     = m_vld;
  assign RegWrite_o  = m_vld & m_q.wb[1];
  assign RegDst_o    = m_q.dst;
  assign WriteData_o = m_q.wb[0] ? m_q.rd : m_q.alu;
  assign fwd_valid_o = RegWrite_o & (|m_q.dst);
  assign retired_o   = cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (CNT_W=4 so the counter wrap is reachable).
module tb_mem_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, valid_i, ready_i;
  logic [1:0]  WB_i;
  logic [31:0] ReadData_i, ALUResult_i;
  logic [4:0]  RegDst_i;
  logic        ready_o, valid_o, RegWrite_o, fwd_valid_o;
  logic [4:0]  RegDst_o;
  logic [31:0] WriteData_o;
  logic [3:0]  retired_o;

  int vectors = 0;
  int miscompares = 0;

  mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .WB_i(WB_i), .ReadData_i(ReadData_i),
    .ALUResult_i(ALUResult_i), .RegDst_i(RegDst_i), .valid_o(valid_o),
    .ready_i(ready_i), .RegWrite_o(RegWrite_o), .RegDst_o(RegDst_o),
    .WriteData_o(WriteData_o), .fwd_valid_o(fwd_valid_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [4:0] dst);
    valid_i = v; WB_i = wb; ReadData_i = rd; ALUResult_i = alu; RegDst_i = dst;
  endtask

  initial begin
    rst_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    #1;
    chk("rst_valid",  32'(valid_o), 32'd0);
    chk("rst_ready",  32'(ready_o), 32'd1);
    chk("rst_regwr",  32'(RegWrite_o), 32'd0);
    chk("rst_fwd",    32'(fwd_valid_o), 32'd0);
    chk("rst_dst",    32'(RegDst_o), 32'd0);
    chk("rst_wdata",  WriteData_o, 32'd0);
    chk("rst_ret",    32'(retired_o), 32'd0);
    tick();
    rst_i = 1'b1;
    tick();

    // Back-to-back stream, one accept and one handoff per cycle
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'b11, 32'h10 + k, 32'h20 + k, 5'(k + 1));
      tick();
      chk("b2b_valid", 32'(valid_o), 32'd1);
      chk("b2b_wdata", WriteData_o, 32'h10 + k);
      chk("b2b_regwr", 32'(RegWrite_o), 32'd1);
      chk("b2b_ret",   32'(retired_o), 32'(k));
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    tick();
    chk("b2b_drain_valid", 32'(valid_o), 32'd0);
    chk("b2b_drain_ret",   32'(retired_o), 32'd4);

    // MemToReg=0 selects the ALU result
    drive(1'b1, 2'b10, 32'h1, 32'hDEADBEEF, 5'd7);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("m2r_wdata", WriteData_o, 32'hDEADBEEF);
    chk("m2r_regwr", 32'(RegWrite_o), 32'd1);
    chk("m2r_fwd",   32'(fwd_valid_o), 32'd1);
    tick();
    chk("m2r_ret", 32'(retired_o), 32'd5);

    // Forwarding qualifier around register 0
    drive(1'b1, 2'b11, 32'h0, 32'h0, 5'd0);
    tick();
    chk("fwd_r0_regwr", 32'(RegWrite_o), 32'd1);
    chk("fwd_r0_fwd",   32'(fwd_valid_o), 32'd0);
    drive(1'b1, 2'b11, 32'h0, 32'h55, 5'd5);
    tick();
    chk("fwd_r5_fwd", 32'(fwd_valid_o), 32'd1);
    chk("fwd_r5_dst", 32'(RegDst_o), 32'd5);
    drive(1'b0, 2'b11, 32'h0, 32'h0, 5'd0);
    tick();
    chk("fwd_drain_valid", 32'(valid_o), 32'd0);
    chk("fwd_drain_fwd",   32'(fwd_valid_o), 32'd0);
    chk("fwd_ret", 32'(retired_o), 32'd7);

    // Backpressure into the skid register
    ready_i = 1'b0;
    drive(1'b1, 2'b01, 32'hA1, 32'h0, 5'd1);
    tick();
    chk("bp_a_ready", 32'(ready_o), 32'd1);
    drive(1'b1, 2'b01, 32'hB2, 32'h0, 5'd2);
    tick();
    chk("bp_b_ready", 32'(ready_o), 32'd0);
    drive(1'b1, 2'b01, 32'hC3, 32'h0, 5'd3);
    tick();
    chk("bp_hold_ready", 32'(ready_o), 32'd0);
    chk("bp_hold_wdata", WriteData_o, 32'hA1);
    chk("bp_hold_ret",   32'(retired_o), 32'd7);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    ready_i = 1'b1;
    chk("bp_a_out", WriteData_o, 32'hA1);
    tick();
    chk("bp_b_valid", 32'(valid_o), 32'd1);
    chk("bp_b_out",   WriteData_o, 32'hB2);
    chk("bp_b_ready2", 32'(ready_o), 32'd1);
    chk("bp_ret8",    32'(retired_o), 32'd8);
    tick();
    chk("bp_empty", 32'(valid_o), 32'd0);
    chk("bp_ret9",  32'(retired_o), 32'd9);

    // Flush with skid full, coinciding with input and a handoff
    ready_i = 1'b0;
    drive(1'b1, 2'b11, 32'hD4, 32'h0, 5'd4);
    tick();
    drive(1'b1, 2'b11, 32'hE5, 32'h0, 5'd6);
    tick();
    chk("fl_full_ready", 32'(ready_o), 32'd0);
    flush_i = 1'b1; ready_i = 1'b1;
    drive(1'b1, 2'b11, 32'hF6, 32'h0, 5'd8);
    tick();
    flush_i = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("fl_valid", 32'(valid_o), 32'd0);
    chk("fl_ready", 32'(ready_o), 32'd1);
    chk("fl_regwr", 32'(RegWrite_o), 32'd0);
    chk("fl_fwd",   32'(fwd_valid_o), 32'd0);
    chk("fl_ret",   32'(retired_o), 32'd9);
    tick();
    chk("fl_after_valid", 32'(valid_o), 32'd0);

    // Asynchronous reset in the middle of a stream
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'b11, 32'h30 + k, 32'h0, 5'd9);
      tick();
    end
    #2;
    rst_i = 1'b0;
    valid_i = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_regwr", 32'(RegWrite_o), 32'd0);
    chk("arst_ret",   32'(retired_o), 32'd0);
    chk("arst_ready", 32'(ready_o), 32'd1);
    #2;
    rst_i = 1'b1;
    tick();
    chk("arst_post_valid", 32'(valid_o), 32'd0);

    // Counter wrap: 17 handoffs on a 4-bit counter
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 2'b11, 32'(k), 32'h0, 5'd3);
      tick();
      if (k == 16) chk("wrap_zero", 32'(retired_o), 32'd0);
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    tick();
    chk("wrap_one", 32'(retired_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
